// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef logic [1:0] state_t;
    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t PRESSED  = 2'd2;
    localparam state_t RELEASE  = 2'd3;

    // Keypad legend, code = row*4 + col
    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_8    = 4'd9;
    localparam logic [3:0] KEY_9    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_0    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    // Index of the lowest low column; column 0 wins when several are pressed.
    function automatic logic [1:0] lowest_low(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-clock tick every CLK_DIV clocks.
module keypad_tick_gen #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and one-clock key_valid pulses.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_TICKS);

    logic            w_tick;
    logic [COLS-1:0] r_col_meta, r_col_s;
    state_t          r_state, w_state_d;
    logic [1:0]      r_row, w_row_d;
    logic [ROWS-1:0] r_row_out;
    logic [1:0]      r_cur_col, w_cur_col_d;
    logic [DB_W-1:0] r_db, w_db_d, w_db_inc;
    logic [3:0]      r_key_code, w_key_code_d;
    logic            r_key_held, w_key_held_d;
    logic            r_key_valid;
    logic            w_accept, w_rpt_fire, w_col_bit;

    keypad_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_meta <= ROW_IDLE;
            r_col_s    <= ROW_IDLE;
        end else begin
            r_col_meta <= col_in;
            r_col_s    <= r_col_meta;
        end
    end

    assign w_col_bit = r_col_s[r_cur_col];
    assign w_db_inc  = (r_db == DB_MAX) ? r_db : r_db + 1'b1;

    always_comb begin
        w_state_d    = r_state;
        w_row_d      = r_row;
        w_cur_col_d  = r_cur_col;
        w_db_d       = r_db;
        w_key_code_d = r_key_code;
        w_key_held_d = r_key_held;
        w_accept     = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (r_col_s != ROW_IDLE) begin
                        w_cur_col_d = lowest_low(r_col_s);
                        w_db_d      = '0;
                        w_state_d   = DEBOUNCE;
                    end else begin
                        w_row_d = r_row + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!w_col_bit) begin
                        w_db_d = w_db_inc;
                        if (w_db_inc == DB_MAX) begin
                            w_key_code_d = {r_row, r_cur_col};
                            w_accept     = 1'b1;
                            w_key_held_d = 1'b1;
                            w_state_d    = PRESSED;
                        end
                    end else begin
                        w_row_d   = r_row + 2'd1;
                        w_state_d = SCAN;
                    end
                end
                PRESSED: begin
                    if (w_col_bit) begin
                        w_db_d    = '0;
                        w_state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_col_bit) begin
                        w_db_d = w_db_inc;
                        if (w_db_inc == DB_MAX) begin
                            w_key_held_d = 1'b0;
                            w_row_d      = r_row + 2'd1;
                            w_state_d    = SCAN;
                        end
                    end else begin
                        w_state_d = PRESSED;
                    end
                end
                default: w_state_d = SCAN;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_TICKS) ? REPEAT_DELAY : REPEAT_TICKS;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt, w_rpt_d, w_rpt_target;
    logic             r_rpt_armed, w_rpt_armed_d;

    // First repeat after REPEAT_DELAY ticks, then every REPEAT_TICKS; held across RELEASE.
    always_comb begin
        w_rpt_d       = r_rpt;
        w_rpt_armed_d = r_rpt_armed;
        w_rpt_fire    = 1'b0;
        w_rpt_target  = r_rpt_armed ? RPT_W'(REPEAT_TICKS) : RPT_W'(REPEAT_DELAY);
        if (w_accept) begin
            w_rpt_d       = '0;
            w_rpt_armed_d = 1'b0;
        end else if (w_tick && (r_state == PRESSED) && !w_col_bit) begin
            if (r_rpt + 1'b1 == w_rpt_target) begin
                w_rpt_fire    = 1'b1;
                w_rpt_d       = '0;
                w_rpt_armed_d = 1'b1;
            end else begin
                w_rpt_d = r_rpt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt       <= '0;
            r_rpt_armed <= 1'b0;
        end else begin
            r_rpt       <= w_rpt_d;
            r_rpt_armed <= w_rpt_armed_d;
        end
    end
`else
    logic w_unused_rpt;
    assign w_unused_rpt = (REPEAT_DELAY != REPEAT_TICKS);
    assign w_rpt_fire   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_row       <= 2'd0;
            r_row_out   <= 4'b1110;
            r_cur_col   <= 2'd0;
            r_db        <= '0;
            r_key_code  <= 4'd0;
            r_key_held  <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_row       <= w_row_d;
            r_row_out   <= ~(4'b0001 << w_row_d);
            r_cur_col   <= w_cur_col_d;
            r_db        <= w_db_d;
            r_key_code  <= w_key_code_d;
            r_key_held  <= w_key_held_d;
            r_key_valid <= w_accept | w_rpt_fire;
        end
    end

    assign row_out   = r_row_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
